// File: rtl/fft_frame_mux.sv
// ---------------------------------------------------------------------------
// fft_frame_mux
//
// Captures NCH ADC sample streams into per-channel frame buffers of
// 2**PTS_LOG2 points and feeds complete frames, one at a time and
// round-robin, into the Avalon-ST sink of a shared FFT core.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   ch_data         NCH packed samples, channel k at [k*DW +: DW]
//   ch_en           per-channel sample strobe (one sample per high cycle)
//   ch_enable       per-channel capture enable mask
//   ovf_clr         clears all sticky overflow flags
//   fft_reset_n     active-low FFT core reset, released two edges after rst
//   sink_*          Avalon-ST source towards the FFT core (ready latency 0)
//   sink_ch         channel index of the frame being delivered
//   ovf             sticky per-channel sample-drop flags
//   dbg_ch_state    per-channel FSM state, channel k at [2*k +: 2]
//                   (0 IDLE, 1 FILL, 2 FULL, 3 DRAIN)
//   dbg_arb_busy    arbiter state, 1 while a frame is draining
//
// Handshake: a beat transfers on a rising edge where sink_valid and
// sink_ready are both 1. Once sink_valid is raised, sink_real, sink_sop,
// sink_eop and sink_ch hold their values until that beat transfers.
// ---------------------------------------------------------------------------
module fft_frame_mux #(
  parameter int NCH      = 4,
  parameter int DW       = 12,
  parameter int PTS_LOG2 = 10,
  parameter int CHW      = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH*DW-1:0]   ch_data,
  input  logic [NCH-1:0]      ch_en,
  input  logic [NCH-1:0]      ch_enable,
  input  logic                ovf_clr,
  output logic                fft_reset_n,
  output logic                sink_valid,
  input  logic                sink_ready,
  output logic                sink_sop,
  output logic                sink_eop,
  output logic [DW-1:0]       sink_real,
  output logic [DW-1:0]       sink_imag,
  output logic [1:0]          sink_error,
  output logic [CHW-1:0]      sink_ch,
  output logic [NCH-1:0]      ovf,
  output logic [2*NCH-1:0]    dbg_ch_state,
  output logic                dbg_arb_busy
);

  localparam int PTS = 1 << PTS_LOG2;
  localparam logic [PTS_LOG2-1:0] LAST_PT = PTS_LOG2'(PTS - 1);

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_FILL  = 2'd1,
    CH_FULL  = 2'd2,
    CH_DRAIN = 2'd3
  } ch_state_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_DRAIN = 1'b1
  } arb_state_t;

  // -------------------------------------------------------------------------
  // FFT core reset: asserted with rst, released through two flops
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b00;
    else     rst_sync <= {rst_sync[0], 1'b1};
  end

  assign fft_reset_n = rst_sync[1];
  assign sink_imag   = '0;
  assign sink_error  = 2'b00;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  ch_state_t             ch_state     [NCH];
  ch_state_t             ch_state_nxt [NCH];
  logic [PTS_LOG2-1:0]   wr_ptr       [NCH];
  logic [PTS_LOG2-1:0]   wr_ptr_nxt   [NCH];
  logic [NCH-1:0]        wr_en;
  logic [NCH-1:0]        drop;
  logic [NCH-1:0]        grant_vec;
  logic [NCH-1:0]        drain_done;
  logic [DW-1:0]         mem [NCH][PTS];

  arb_state_t            arb_state;
  arb_state_t            arb_state_nxt;
  logic [CHW-1:0]        arb_ptr;
  logic [CHW-1:0]        act_ch;
  logic [CHW-1:0]        gnt_idx;
  logic                  gnt_found;
  logic                  grant;
  logic                  xfer;
  logic                  eop_accept;
  logic                  advance;
  logic [PTS_LOG2-1:0]   rd_ptr;
  logic                  rd_pending;
  logic [DW-1:0]         rd_data;

  assign xfer       = sink_valid & sink_ready;
  assign eop_accept = xfer & sink_eop;

  // -------------------------------------------------------------------------
  // Per-channel capture FSMs: next state and write/drop decisions
  // -------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ch_state_nxt[k] = ch_state[k];
      wr_ptr_nxt[k]   = wr_ptr[k];
      wr_en[k]        = 1'b0;
      drop[k]         = 1'b0;
      case (ch_state[k])
        CH_IDLE: begin
          // wr_ptr is always 0 in IDLE, so this sample lands at point 0
          if (ch_en[k] && ch_enable[k]) begin
            wr_en[k]        = 1'b1;
            wr_ptr_nxt[k]   = PTS_LOG2'(1);
            ch_state_nxt[k] = CH_FILL;
          end
        end
        CH_FILL: begin
          // Losing the enable mid-frame discards the partial frame
          if (!ch_enable[k]) begin
            wr_ptr_nxt[k]   = '0;
            ch_state_nxt[k] = CH_IDLE;
          end else if (ch_en[k]) begin
            wr_en[k] = 1'b1;
            if (wr_ptr[k] == LAST_PT) begin
              wr_ptr_nxt[k]   = '0;
              ch_state_nxt[k] = CH_FULL;
            end else begin
              wr_ptr_nxt[k] = wr_ptr[k] + PTS_LOG2'(1);
            end
          end
        end
        CH_FULL: begin
          drop[k] = ch_en[k];
          if (grant_vec[k]) ch_state_nxt[k] = CH_DRAIN;
        end
        CH_DRAIN: begin
          drop[k] = ch_en[k];
          if (drain_done[k]) ch_state_nxt[k] = CH_IDLE;
        end
        default: ch_state_nxt[k] = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        ch_state[k] <= CH_IDLE;
        wr_ptr[k]   <= '0;
      end
      ovf <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        ch_state[k] <= ch_state_nxt[k];
        wr_ptr[k]   <= wr_ptr_nxt[k];
        // A drop in the same cycle as a clear wins, so no drop goes unseen
        if (drop[k])      ovf[k] <= 1'b1;
        else if (ovf_clr) ovf[k] <= 1'b0;
      end
    end
  end

  // Frame buffers: one write port per channel, no reset on storage
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (wr_en[k]) mem[k][wr_ptr[k]] <= ch_data[k*DW +: DW];
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin arbiter: search from arb_ptr upwards, wrapping
  // -------------------------------------------------------------------------
  always_comb begin : arb_search
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(arb_ptr) + i) % NCH;
      if (!gnt_found && ch_state[idx] == CH_FULL) begin
        gnt_found = 1'b1;
        gnt_idx   = CHW'(idx);
      end
    end
  end

  // A new grant may be issued in the same cycle the eop beat is accepted
  assign grant = gnt_found && ((arb_state == ARB_IDLE) || eop_accept);

  always_comb begin
    grant_vec  = '0;
    drain_done = '0;
    for (int k = 0; k < NCH; k++) begin
      grant_vec[k]  = grant && (gnt_idx == CHW'(k));
      drain_done[k] = eop_accept && (act_ch == CHW'(k));
    end
  end

  always_comb begin
    arb_state_nxt = arb_state;
    if (grant)           arb_state_nxt = ARB_DRAIN;
    else if (eop_accept) arb_state_nxt = ARB_IDLE;
  end

  // -------------------------------------------------------------------------
  // Readout: the buffer read is registered straight into sink_real, so the
  // next point is fetched only when the output slot is free next cycle.
  // -------------------------------------------------------------------------
  assign advance = (arb_state == ARB_DRAIN) && rd_pending &&
                   (!sink_valid || sink_ready);

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (act_ch == CHW'(k)) rd_data = mem[k][rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_state  <= ARB_IDLE;
      arb_ptr    <= '0;
      act_ch     <= '0;
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
      sink_valid <= 1'b0;
      sink_sop   <= 1'b0;
      sink_eop   <= 1'b0;
      sink_real  <= '0;
      sink_ch    <= '0;
    end else begin
      arb_state <= arb_state_nxt;

      if (grant) begin
        act_ch     <= gnt_idx;
        arb_ptr    <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
        rd_ptr     <= '0;
        rd_pending <= 1'b1;
      end else if (advance) begin
        rd_ptr <= rd_ptr + PTS_LOG2'(1);
        if (rd_ptr == LAST_PT) rd_pending <= 1'b0;
      end

      if (advance) begin
        sink_valid <= 1'b1;
        sink_real  <= rd_data;
        sink_sop   <= (rd_ptr == '0);
        sink_eop   <= (rd_ptr == LAST_PT);
        sink_ch    <= act_ch;
      end else if (xfer) begin
        sink_valid <= 1'b0;
        sink_sop   <= 1'b0;
        sink_eop   <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Debug state view
  // -------------------------------------------------------------------------
  always_comb begin
    dbg_ch_state = '0;
    for (int k = 0; k < NCH; k++) begin
      dbg_ch_state[2*k +: 2] = ch_state[k];
    end
  end

  assign dbg_arb_busy = (arb_state == ARB_DRAIN);

endmodule

// File: tb/tb_fft_frame_mux.sv
// ---------------------------------------------------------------------------
// Directed bench for fft_frame_mux with NCH=2, DW=12, PTS_LOG2=3 (8 points).
// Beats are captured on the falling edge into got_q as {ch, sop, eop, data}
// and compared against hand-built frames in exp_q.
// ---------------------------------------------------------------------------
module tb_fft_frame_mux;

  localparam int NCH = 2;
  localparam int DW  = 12;
  localparam int PL2 = 3;
  localparam int CHW = 1;
  localparam int W   = CHW + 2 + DW;

  // ---------------- clock / reset ----------------
  logic              clk;
  logic              rst;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    ch_enable;
  logic              ovf_clr;
  logic              fft_reset_n;
  logic              sink_valid;
  logic              sink_ready;
  logic              sink_sop;
  logic              sink_eop;
  logic [DW-1:0]     sink_real;
  logic [DW-1:0]     sink_imag;
  logic [1:0]        sink_error;
  logic [CHW-1:0]    sink_ch;
  logic [NCH-1:0]    ovf;
  logic [2*NCH-1:0]  dbg_ch_state;
  logic              dbg_arb_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fft_frame_mux #(.NCH(NCH), .DW(DW), .PTS_LOG2(PL2), .CHW(CHW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_data      (ch_data),
    .ch_en        (ch_en),
    .ch_enable    (ch_enable),
    .ovf_clr      (ovf_clr),
    .fft_reset_n  (fft_reset_n),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .sink_error   (sink_error),
    .sink_ch      (sink_ch),
    .ovf          (ovf),
    .dbg_ch_state (dbg_ch_state),
    .dbg_arb_busy (dbg_arb_busy)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           cyc_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Falling-edge monitor: record accepted beats and check hold-while-stalled
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_beat  = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(sink_valid), 32'd1);
        check("stall_hold", 32'({sink_ch, sink_sop, sink_eop, sink_real}), 32'(prev_beat));
      end
      if (sink_valid && sink_ready) begin
        got_q.push_back({sink_ch, sink_sop, sink_eop, sink_real});
        cyc_q.push_back(cyc);
      end
      prev_stall = sink_valid && !sink_ready;
      prev_beat  = {sink_ch, sink_sop, sink_eop, sink_real};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [1:0] mask, input logic [11:0] b0,
                      input logic [11:0] b1, input int n);
    for (int i = 0; i < n; i++) begin
      ch_en   = mask;
      ch_data = {12'(b1 + 12'(i)), 12'(b0 + 12'(i))};
      step();
    end
    ch_en = '0;
  endtask

  task automatic push_frame(input logic ch, input logic [11:0] base);
    for (int i = 0; i < 8; i++)
      exp_q.push_back({ch, (i == 0), (i == 7), 12'(base + 12'(i))});
  endtask

  // Bounded wait for n beats, then a few extra cycles to expose extra beats
  task automatic wait_beats(input int n, input bit toggle);
    for (int c = 0; c < 300; c++) begin
      if (got_q.size() >= n) break;
      if (toggle) sink_ready = ~sink_ready;
      step();
    end
    sink_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic compare_frames(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
    cyc_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(sink_valid), 32'd0);
    check({tag, "_sop_eop"}, 32'({sink_sop, sink_eop}), 32'd0);
    check({tag, "_real"}, 32'(sink_real), 32'd0);
    check({tag, "_ch"}, 32'(sink_ch), 32'd0);
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
    check({tag, "_fft_rst_n"}, 32'(fft_reset_n), 32'd0);
    check({tag, "_states"}, 32'(dbg_ch_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; ch_data = '0; ch_en = '0; ch_enable = '0;
    ovf_clr = 1'b0; sink_ready = 1'b1;
    step(); step();
    check_reset_state("rst0");
    check("imag_zero", 32'(sink_imag), 32'd0);
    check("error_zero", 32'(sink_error), 32'd0);
    rst = 1'b0;
    step();
    check("fft_rst_n_edge1", 32'(fft_reset_n), 32'd0);
    step();
    check("fft_rst_n_edge2", 32'(fft_reset_n), 32'd1);

    // S1: single frame, ready held high
    ch_enable = 2'b01;
    fill(2'b01, 12'h001, 12'h000, 8);
    push_frame(1'b0, 12'h001);
    wait_beats(8, 1'b0);
    if (cyc_q.size() >= 8) check("s1_back_to_back", 32'(cyc_q[7] - cyc_q[0]), 32'd7);
    compare_frames("s1_beat");
    check("s1_ovf", 32'(ovf), 32'd0);

    // S2: same frame with ready toggling every cycle
    fill(2'b01, 12'h001, 12'h000, 8);
    push_frame(1'b0, 12'h001);
    wait_beats(8, 1'b1);
    compare_frames("s2_beat");

    // Reset to bring the round-robin pointer back to channel 0
    rst = 1'b1; step();
    check_reset_state("rst1");
    rst = 1'b0; step(); step();

    // S3: both channels together, two rounds
    ch_enable = 2'b11;
    fill(2'b11, 12'h100, 12'h200, 8);
    push_frame(1'b0, 12'h100);
    push_frame(1'b1, 12'h200);
    wait_beats(16, 1'b0);
    if (cyc_q.size() >= 16) begin
      check("s3_ch0_contig", 32'(cyc_q[7] - cyc_q[0]), 32'd7);
      check("s3_ch1_contig", 32'(cyc_q[15] - cyc_q[8]), 32'd7);
      check("s3_gap_max1", 32'((cyc_q[8] - cyc_q[7]) <= 2), 32'd1);
    end
    compare_frames("s3_round1");
    fill(2'b11, 12'h110, 12'h210, 8);
    push_frame(1'b0, 12'h110);
    push_frame(1'b1, 12'h210);
    wait_beats(16, 1'b0);
    compare_frames("s3_round2");

    // S4: overflow while stalled, clear vs drop priority
    ch_enable  = 2'b01;
    sink_ready = 1'b0;
    fill(2'b01, 12'h040, 12'h000, 8);
    fill(2'b01, 12'h0A0, 12'h000, 14);
    check("s4_ovf_set", 32'(ovf), 32'h1);
    check("s4_stall_first", 32'({sink_valid, sink_sop, sink_real}), 32'h3040);
    ch_en = 2'b01; ovf_clr = 1'b1; step();
    check("s4_clr_vs_drop", 32'(ovf), 32'h1);
    ch_en = 2'b00; step();
    ovf_clr = 1'b0;
    check("s4_ovf_cleared", 32'(ovf), 32'h0);
    push_frame(1'b0, 12'h040);
    sink_ready = 1'b1;
    wait_beats(8, 1'b0);
    compare_frames("s4_beat");

    // S5: enable dropped mid-fill, then a clean frame
    fill(2'b01, 12'h030, 12'h000, 4);
    ch_enable = 2'b00; step();
    ch_enable = 2'b01;
    fill(2'b01, 12'h010, 12'h000, 8);
    push_frame(1'b0, 12'h010);
    wait_beats(8, 1'b0);
    compare_frames("s5_beat");
    check("s5_ovf", 32'(ovf), 32'd0);

    // S6: reset in the middle of a drain
    fill(2'b01, 12'h050, 12'h000, 8);
    for (int c = 0; c < 100; c++) begin
      if (got_q.size() >= 5) break;
      step();
    end
    check("s6_reached_pt5", 32'(got_q.size() >= 5), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("s6_async_valid", 32'(sink_valid), 32'd0);
    check("s6_async_fft_rst", 32'(fft_reset_n), 32'd0);
    got_q.delete(); cyc_q.delete(); exp_q.delete();
    step();
    rst = 1'b0;
    step();
    check("s6_fft_rst_n_edge1", 32'(fft_reset_n), 32'd0);
    step();
    check("s6_fft_rst_n_edge2", 32'(fft_reset_n), 32'd1);
    check("s6_idle_after_rst", 32'(sink_valid), 32'd0);
    fill(2'b01, 12'h060, 12'h000, 8);
    push_frame(1'b0, 12'h060);
    wait_beats(8, 1'b0);
    compare_frames("s6_beat");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
